clkgen_ctrl: RTL and testbench
==============================

# clkgen_ctrl

Synthesizable programmable clock-enable generator and its sequencer. It accepts a frequency/duty/phase configuration over a valid/ready port and converts it to high and low cycle counts. It then drives a divided, glitch-free `clk_out` from the 100 MHz reference clock. Reconfiguration is applied only at period boundaries. The block replaces simulation-only delay-based clock generation wherever a divided clock or strobe is needed in the design.

## Interface
- `CNT_W`, 16: width of period, phase and internal counters.
- `clk`  in  1  reference clock (100 MHz); all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  block can accept a configuration.
- `cfg_period`  in  CNT_W  output period in `clk` cycles.
- `cfg_duty`  in  8  duty as a fraction of 256.
- `cfg_phase`  in  CNT_W  cycles of low before the first rising edge after start.
- `en`  in  1  run request.
- `clk_out`  out  1  generated clock, registered.
- `period_tick`  out  1  one-cycle pulse on the first high cycle of every period.
- `busy`  out  1  FSM not in IDLE.
- `cfg_err`  out  1  one-cycle pulse when an illegal configuration is rejected.

## Operation
- **Handshake:** a transfer occurs when `cfg_valid && cfg_ready`. `cfg_ready` = 1 when no computed config is pending.
- **Rejection:** `cfg_period < 2` is rejected. The transfer still completes, `cfg_err` pulses the next cycle, and nothing is stored.
- **CALC stage (1 cycle):**
  - `high = (cfg_period * cfg_duty) >> 8`, computed with a CNT_W+8-bit product.
  - Clamp `high` to a minimum of 1 and a maximum of `period-1`.
  - `low = period - high`.
  - The result is written to the pending register with `phase`. `pend_valid` is set.
- **Active register:** holds {high, low, phase} and an `act_valid` flag. Both are cleared by reset.
- **FSM states:**
  - **IDLE:** `clk_out` = 0.
    - If `pend_valid`, copy pending to active, even with `en` = 0.
    - If `en && act_valid`, go to PHASE when phase > 0, otherwise to HIGH.
  - **PHASE:** `clk_out` = 0 for `phase` cycles, then HIGH. If `en` drops, go to IDLE next cycle.
  - **HIGH:** `clk_out` = 1 for `high` cycles, then LOW.
  - **LOW:** `clk_out` = 0 for `low` cycles.
    - On the last LOW cycle, if `pend_valid`, load pending to active and clear `pend_valid`.
    - Then go to HIGH if `en`, otherwise to IDLE.
    - Phase is not re-applied on reconfiguration.
- **Stopping:** dropping `en` during HIGH or LOW completes the current period. No runt pulses.
- **Outputs:**
  - `period_tick` = 1 exactly on the cycle HIGH is entered.
  - `busy` = (state != IDLE).
- **Simultaneous events:** a pending load and a new `cfg_valid` in the same cycle: the load wins. `cfg_ready` goes high the following cycle.
- **Reset:**
  - Applies mid-period at the next edge.
  - `clk_out`, `period_tick`, `busy`, `cfg_err` and `pend_valid`/`act_valid` all go to 0. `cfg_ready` goes to 1 and state to IDLE.
  - Counters are zeroed.

## Timing
- **Config latency:** transfer at edge T; pending valid after T+1; `cfg_ready` low from T+1 until consumed.
- **Start:** with `act_valid` and `en` sampled high at edge S, `clk_out` rises at edge S+1+phase.
- **Steady state:** `clk_out` period = high+low = period exactly. Duty error is below 1 cycle (truncation).
- **Reconfiguration:** new values take effect on the first HIGH after the current LOW ends.
- **Counters:** count down from value-1 to 0. No wrap; a maximum period of 2^CNT_W-1 is supported.

## Test plan
- **Basic run:** reset; cfg period=10, duty=128, phase=0; `en`=1 → `clk_out` 5 high / 5 low repeating; `period_tick` every 10 cycles; `busy`=1.
- **Phase offset:** cfg period=10, duty=128, phase=2; `en` rises at S → first rising edge at S+3; subsequent periods have no added phase.
- **Clamping and rejection:**
  - period=4, duty=0 → high=1, low=3.
  - period=3, duty=255 → high=2, low=1.
  - period=1 → `cfg_err` pulse, output unchanged.
- **Reconfiguration:** running period=10; send period=6, duty=64 mid-HIGH → current period completes 5/5, then 1 high / 5 low; `cfg_ready` low until the boundary, and a second cfg is stalled.
- **Stop and reset:**
  - Drop `en` mid-HIGH → period completes, then IDLE with `clk_out`=0 and `busy`=0.
  - Assert `rst` mid-HIGH → `clk_out`=0 and `cfg_ready`=1 next cycle; with `en`=1 and no new cfg, the block stays IDLE.

Source files
------------

// File: rtl/clkgen_ctrl.sv
// clkgen_ctrl: programmable divided clock generator with config pipeline and boundary-only reconfiguration
module clkgen_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [7:0]       cfg_duty,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             en,
    output logic             clk_out,
    output logic             period_tick,
    output logic             busy,
    output logic             cfg_err
);
    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;
    state_t state;
    logic             c_valid, pend_valid, act_valid;
    logic [CNT_W-1:0] c_period, c_phase;
    logic [7:0]       c_duty;
    logic [CNT_W-1:0] pend_high, pend_low, pend_phase;
    logic [CNT_W-1:0] act_high, act_low, act_phase;
    logic [CNT_W-1:0] cnt, calc_raw, calc_high;
    logic             xfer, last;
    assign calc_raw  = CNT_W'(({8'd0, c_period} * {{CNT_W{1'b0}}, c_duty}) >> 8);
    assign calc_high = (calc_raw == '0) ? CNT_W'(1) :
                       (calc_raw >= c_period) ? c_period - CNT_W'(1) : calc_raw;
    assign cfg_ready = !c_valid && !pend_valid;
    assign xfer      = cfg_valid && cfg_ready;
    assign last      = (cnt == '0);
    assign busy      = (state != IDLE);
    // clk_out and period_tick trail the state by one cycle so both are clean flop outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            c_valid     <= 1'b0;
            pend_valid  <= 1'b0;
            act_valid   <= 1'b0;
            cnt         <= '0;
            clk_out     <= 1'b0;
            period_tick <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            clk_out     <= (state == HIGH);
            period_tick <= (state == HIGH) && !clk_out;
            cfg_err     <= xfer && (cfg_period < CNT_W'(2));
            c_valid     <= xfer && (cfg_period >= CNT_W'(2));
            if (xfer) begin
                c_period <= cfg_period;
                c_duty   <= cfg_duty;
                c_phase  <= cfg_phase;
            end
            if (c_valid) begin
                pend_high  <= calc_high;
                pend_low   <= c_period - calc_high;
                pend_phase <= c_phase;
                pend_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        act_high   <= pend_high;
                        act_low    <= pend_low;
                        act_phase  <= pend_phase;
                        act_valid  <= 1'b1;
                        pend_valid <= 1'b0;
                    end else if (en && act_valid) begin
                        state <= (act_phase != '0) ? PHASE : HIGH;
                        cnt   <= (act_phase != '0) ? act_phase - CNT_W'(1) : act_high - CNT_W'(1);
                    end
                end
                PHASE: begin
                    if (!en) state <= IDLE;
                    else if (last) begin
                        state <= HIGH;
                        cnt   <= act_high - CNT_W'(1);
                    end else cnt <= cnt - CNT_W'(1);
                end
                HIGH: begin
                    if (last) begin
                        state <= LOW;
                        cnt   <= act_low - CNT_W'(1);
                    end else cnt <= cnt - CNT_W'(1);
                end
                LOW: begin
                    if (last) begin
                        if (pend_valid) begin
                            act_high   <= pend_high;
                            act_low    <= pend_low;
                            act_phase  <= pend_phase;
                            pend_valid <= 1'b0;
                        end
                        state <= en ? HIGH : IDLE;
                        cnt   <= pend_valid ? pend_high - CNT_W'(1) : act_high - CNT_W'(1);
                    end else cnt <= cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clkgen_ctrl.sv
// tb_clkgen_ctrl: directed and random stimulus checked against a waveform-schedule model
module tb_clkgen_ctrl;
    localparam int CNT_W = 16;
    logic             clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, en = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0, cfg_phase = '0;
    logic [7:0]       cfg_duty = '0;
    logic             cfg_ready, clk_out, period_tick, busy, cfg_err;
    int               errors = 0, checks = 0;
    // model: q holds the upcoming per-cycle generator activity (0 phase, 1 first high, 2 high, 3 low)
    int q[$];
    bit cv, pv, av, m_clk, m_tick, m_err;
    int c_p, c_d, c_ph, p_h, p_l, p_ph, a_h, a_l, a_ph;

    always #5 clk = ~clk;

    clkgen_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
        .en(en), .clk_out(clk_out), .period_tick(period_tick), .busy(busy), .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_period();
        q.push_back(1);
        repeat (a_h - 1) q.push_back(2);
        repeat (a_l) q.push_back(3);
    endtask

    task automatic step();
        int f;
        bit x;
        if (rst) begin
            q.delete();
            {cv, pv, av, m_clk, m_tick, m_err} = '0;
            return;
        end
        f = (q.size() != 0) ? q[0] : -1;
        x = cfg_valid && !cv && !pv;
        m_clk  = (f == 1) || (f == 2);
        m_tick = (f == 1);
        m_err  = x && (cfg_period < 2);
        if (q.size() == 0) begin
            if (pv) begin
                a_h = p_h; a_l = p_l; a_ph = p_ph; av = 1; pv = 0;
            end else if (en && av) begin
                repeat (a_ph) q.push_back(0);
                push_period();
            end
        end else begin
            void'(q.pop_front());
            if (f == 0 && !en) q.delete();
            else if (f == 3 && q.size() == 0) begin
                if (pv) begin
                    a_h = p_h; a_l = p_l; a_ph = p_ph; pv = 0;
                end
                if (en) push_period();
            end
        end
        if (cv) begin
            p_h = (c_p * c_d) / 256;
            if (p_h < 1) p_h = 1;
            if (p_h > c_p - 1) p_h = c_p - 1;
            p_l = c_p - p_h;
            p_ph = c_ph;
            pv = 1;
            cv = 0;
        end
        if (x && cfg_period >= 2) begin
            cv = 1; c_p = int'(cfg_period); c_d = int'(cfg_duty); c_ph = int'(cfg_phase);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        step();
        @(negedge clk);
        chk("clk_out", clk_out, m_clk);
        chk("period_tick", period_tick, m_tick);
        chk("busy", busy, q.size() != 0);
        chk("cfg_ready", cfg_ready, !cv && !pv);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input int p, input int d, input int ph);
        bit rdy = 0;
        cfg_valid = 1; cfg_period = CNT_W'(p); cfg_duty = 8'(d); cfg_phase = CNT_W'(ph);
        for (int i = 0; i < 100 && !rdy; i++) begin
            rdy = !cv && !pv;
            cycle();
        end
        chk("send_timeout", rdy, 1);
        cfg_valid = 0;
    endtask

    task automatic wait_high();
        for (int i = 0; i < 60 && !clk_out; i++) cycle();
        chk("wait_high", clk_out, 1);
    endtask

    task automatic window(input string tag, input int n, input int hi, input int tk);
        int h = 0, t = 0;
        repeat (n) begin
            cycle();
            h += int'(clk_out);
            t += int'(period_tick);
        end
        chk({tag, "_highs"}, h, hi);
        chk({tag, "_ticks"}, t, tk);
    endtask

    initial begin
        run(3);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 0;
        run(2);
        // basic run 5/5
        send(10, 128, 0);
        run(3);
        en = 1;
        run(12);
        window("basic", 20, 10, 2);
        chk("basic_busy", busy, 1);
        // stop mid-high
        wait_high();
        cycle();
        en = 0;
        run(15);
        chk("stop_busy", busy, 0);
        chk("stop_clk_out", clk_out, 0);
        // phase offset of 2
        send(10, 128, 2);
        run(4);
        en = 1;
        run(3);
        chk("phase_low", clk_out, 0);
        cycle();
        chk("phase_rise", clk_out, 1);
        run(25);
        // reconfiguration mid-high with a second cfg stalled behind it
        wait_high();
        send(6, 64, 0);
        chk("reconf_stall", cfg_ready, 0);
        send(10, 128, 0);
        run(40);
        // clamping and rejection
        send(4, 0, 0);
        run(30);
        window("clamp_lo", 8, 2, 2);
        send(3, 255, 0);
        run(20);
        window("clamp_hi", 6, 4, 2);
        send(1, 77, 0);
        chk("reject_err", cfg_err, 1);
        cycle();
        chk("reject_clear", cfg_err, 0);
        run(6);
        window("reject_keep", 6, 4, 2);
        // reset mid-high
        send(10, 128, 0);
        run(30);
        wait_high();
        rst = 1;
        cycle();
        chk("rst_mid_clk_out", clk_out, 0);
        chk("rst_mid_ready", cfg_ready, 1);
        rst = 0;
        run(20);
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_clk_out", clk_out, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_period = CNT_W'($urandom_range(0, 24));
            cfg_duty   = 8'($urandom_range(0, 255));
            cfg_phase  = CNT_W'($urandom_range(0, 4));
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
